// File: rtl/cv32e40p_security_marker_checker.sv
// Marker checker between fetch and decode: enforces a marker every WWDL instructions,
// strips markers to NOPs and raises a sticky alarm on a missing marker.
module cv32e40p_security_marker_checker #(
    parameter int          WWDL   = 8,
    parameter logic [31:0] MARKER = 32'h0000006F,
    parameter logic [31:0] NOP    = 32'h00000013,
    parameter int          CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic             instr_valid_i,
    input  logic [31:0]      instr_i,
    output logic             instr_ready_o,
    output logic             instr_valid_o,
    output logic [31:0]      instr_o,
    input  logic             instr_ready_i,
    output logic             is_marker_o,
    output logic             alarm_o,
    output logic [CNT_W-1:0] alarm_cnt_o,
    input  logic             clear_alarm_i
);

    localparam int          CW    = $clog2(WWDL + 1);
    localparam logic [CW-1:0] LIMIT = CW'(WWDL);

    typedef enum logic [1:0] {IDLE, CHECK, ALARM} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic             vld_p1;
    logic [31:0]      instr_p1;
    logic             marker_p1;
    logic [CNT_W-1:0] alarm_cnt;

    logic accept, checking, word_nz, hit_marker, hit_disc, violation;

    // Control-flow discontinuities: compressed jumps/branches and 32-bit branch/jal/jalr.
    function automatic logic is_disc(input logic [31:0] w);
        logic d;
        d = 1'b0;
        case (w[1:0])
            2'b01:   d = (w[15:13] == 3'b001) || (w[15:13] >= 3'b101);
            2'b10:   d = (w[15:13] == 3'b100) && (w[6:2] == 5'd0) && (w[11:7] != 5'd0);
            2'b11:   d = (w[6:2] == 5'b11000) || (w[6:2] == 5'b11011) ||
                         ((w[6:2] == 5'b11001) && (w[14:12] == 3'b000));
            default: d = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign instr_ready_o = !vld_p1 || instr_ready_i;
    assign accept        = instr_valid_i && instr_ready_o;
    assign checking      = enable_i && (state != IDLE);
    assign word_nz       = (instr_i != 32'd0);
    assign hit_marker    = checking && accept && (instr_i == MARKER);
    assign hit_disc      = is_disc(instr_i);
    assign violation     = checking && accept && word_nz && (instr_i != MARKER) &&
                           !hit_disc && (cnt == LIMIT);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable_i) state_next = CHECK;
            CHECK: begin
                if (!enable_i)      state_next = IDLE;
                else if (violation) state_next = ALARM;
            end
            ALARM: begin
                if (!enable_i)                       state_next = IDLE;
                else if (clear_alarm_i && !violation) state_next = CHECK;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Stage 0: distance counter since the last marker or discontinuity.
    always_ff @(posedge clk) begin
        if (!rst_n || state == IDLE) begin
            cnt <= '0;
        end else if (checking && accept && word_nz) begin
            if ((instr_i == MARKER) || hit_disc || (cnt == LIMIT)) cnt <= '0;
            else                                                   cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)         alarm_cnt <= '0;
        else if (violation) alarm_cnt <= sat_inc(alarm_cnt);
    end

    // Stage 1: output register, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            instr_p1  <= 32'd0;
            marker_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1    <= 1'b1;
            instr_p1  <= hit_marker ? NOP : instr_i;
            marker_p1 <= hit_marker;
        end else if (instr_ready_i) begin
            vld_p1    <= 1'b0;
        end
    end

    assign instr_valid_o = vld_p1;
    assign instr_o       = instr_p1;
    assign is_marker_o   = marker_p1;
    assign alarm_o       = (state == ALARM);
    assign alarm_cnt_o   = alarm_cnt;

endmodule

// File: tb/tb_cv32e40p_security_marker_checker.sv
// Directed bench for the marker checker with WWDL=4 and a scoreboard on the output handshake.
module tb_cv32e40p_security_marker_checker;

    localparam logic [31:0] MARKER = 32'h0000006F;
    localparam logic [31:0] NOP    = 32'h00000013;
    localparam logic [31:0] ADDI   = 32'h00100093;
    localparam logic [31:0] JAL    = 32'h0080006F;
    localparam logic [31:0] RET    = 32'h00008067;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable_i = 1'b0;
    logic        instr_valid_i = 1'b0;
    logic [31:0] instr_i = 32'd0;
    logic        instr_ready_o;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic        instr_ready_i = 1'b1;
    logic        is_marker_o;
    logic        alarm_o;
    logic [7:0]  alarm_cnt_o;
    logic        clear_alarm_i = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    logic strip = 1'b1;
    logic [31:0] exp_w[$];
    logic        exp_m[$];

    always #5 clk = ~clk;

    cv32e40p_security_marker_checker #(.WWDL(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable_i),
        .instr_valid_i(instr_valid_i), .instr_i(instr_i), .instr_ready_o(instr_ready_o),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_ready_i(instr_ready_i),
        .is_marker_o(is_marker_o), .alarm_o(alarm_o), .alarm_cnt_o(alarm_cnt_o),
        .clear_alarm_i(clear_alarm_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sample on the falling edge, then advance past the next rising edge.
    task automatic cycle();
        logic [31:0] w;
        logic        m;
        @(negedge clk);
        if (!rst_n) begin
            exp_w.delete();
            exp_m.delete();
        end else begin
            if (instr_valid_o && instr_ready_i) begin
                chk("sb_nonempty", {31'd0, exp_w.size() != 0}, 32'd1);
                if (exp_w.size() != 0) begin
                    w = exp_w.pop_front();
                    m = exp_m.pop_front();
                    chk("sb_instr", instr_o, w);
                    chk("sb_marker", {31'd0, is_marker_o}, {31'd0, m});
                end
            end
            if (instr_valid_i && instr_ready_o) begin
                exp_w.push_back((strip && instr_i == MARKER) ? NOP : instr_i);
                exp_m.push_back(strip && instr_i == MARKER);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        instr_valid_i = 1'b1;
        instr_i = w;
        cycle();
        instr_valid_i = 1'b0;
        instr_i = 32'd0;
    endtask

    initial begin
        cycle();
        cycle();
        chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_marker", {31'd0, is_marker_o}, 32'd0);
        chk("rst_alarm", {31'd0, alarm_o}, 32'd0);
        chk("rst_alarm_cnt", {24'd0, alarm_cnt_o}, 32'd0);
        chk("rst_ready", {31'd0, instr_ready_o}, 32'd1);
        rst_n = 1'b1;
        enable_i = 1'b1;
        cycle();

        // Four instructions then a marker: at the limit, no alarm.
        for (int i = 0; i < 4; i++) send(ADDI);
        send(MARKER);
        chk("t1_alarm", {31'd0, alarm_o}, 32'd0);

        // Five unmarked instructions: the fifth trips the alarm.
        for (int i = 0; i < 4; i++) send(ADDI);
        chk("t2_alarm_pre", {31'd0, alarm_o}, 32'd0);
        send(ADDI);
        chk("t2_alarm", {31'd0, alarm_o}, 32'd1);
        chk("t2_alarm_cnt", {24'd0, alarm_cnt_o}, 32'd1);

        // Clear coinciding with a second violation keeps the alarm.
        for (int i = 0; i < 4; i++) send(ADDI);
        clear_alarm_i = 1'b1;
        send(ADDI);
        clear_alarm_i = 1'b0;
        chk("t5_alarm_kept", {31'd0, alarm_o}, 32'd1);
        chk("t5_alarm_cnt", {24'd0, alarm_cnt_o}, 32'd2);
        clear_alarm_i = 1'b1;
        cycle();
        clear_alarm_i = 1'b0;
        chk("t5_alarm_clr", {31'd0, alarm_o}, 32'd0);

        // Discontinuities restart the window; zero words do not count.
        for (int i = 0; i < 3; i++) send(ADDI);
        send(JAL);
        for (int i = 0; i < 4; i++) send(ADDI);
        chk("t3_jal_alarm", {31'd0, alarm_o}, 32'd0);
        send(32'd0);
        chk("t3_zero_alarm", {31'd0, alarm_o}, 32'd0);
        send(MARKER);
        for (int i = 0; i < 3; i++) send(ADDI);
        send(RET);
        for (int i = 0; i < 4; i++) send(ADDI);
        chk("t3_ret_alarm", {31'd0, alarm_o}, 32'd0);
        chk("t3_alarm_cnt", {24'd0, alarm_cnt_o}, 32'd2);

        // Backpressure with a stripped marker held in the output register.
        cycle();
        instr_ready_i = 1'b0;
        send(MARKER);
        instr_valid_i = 1'b1;
        instr_i = ADDI;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_ready", {31'd0, instr_ready_o}, 32'd0);
            chk("bp_instr", instr_o, NOP);
            chk("bp_marker", {31'd0, is_marker_o}, 32'd1);
        end
        instr_valid_i = 1'b0;
        instr_i = 32'd0;
        instr_ready_i = 1'b1;
        cycle();
        chk("bp_once", {31'd0, instr_valid_o}, 32'd0);

        // Disabled: markers pass through untouched.
        enable_i = 1'b0;
        cycle();
        strip = 1'b0;
        send(MARKER);
        cycle();
        chk("dis_alarm", {31'd0, alarm_o}, 32'd0);

        // Reset during a stall discards the held word.
        instr_ready_i = 1'b0;
        send(ADDI);
        cycle();
        chk("stall_valid", {31'd0, instr_valid_o}, 32'd1);
        rst_n = 1'b0;
        cycle();
        chk("rst_mid_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst_mid_alarm_cnt", {24'd0, alarm_cnt_o}, 32'd0);
        rst_n = 1'b1;
        instr_ready_i = 1'b1;
        cycle();
        chk("sb_drained", exp_w.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
